// File: rtl/cbd_poly_writer.sv
// cbd_poly_writer: takes 48-bit beats of sixteen signed 3-bit CBD noise
// coefficients, maps each to its canonical mod-Q 12-bit value, packs
// WR_COEFFS of them per word and writes one 256-coefficient polynomial
// into the polynomial RAM starting at a latched base address. A 2-entry
// beat buffer decouples the sampler burst rate from the RAM write rate.
module cbd_poly_writer #(
  parameter int Q         = 3329,
  parameter int WR_COEFFS = 4,
  parameter int ADDR_W    = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_start,
  input  logic [ADDR_W-1:0]       i_base_addr,
  input  logic [47:0]             i_coeffs,
  input  logic                    i_coeffs_valid,
  output logic                    o_coeffs_ready,
  output logic                    o_mem_wen,
  output logic [ADDR_W-1:0]       o_mem_addr,
  output logic [12*WR_COEFFS-1:0] o_mem_wdata,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int SLOTS   = 16 / WR_COEFFS;
  localparam int NWORDS  = 256 / WR_COEFFS;
  localparam int SLOT_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int WD_W    = 12 * WR_COEFFS;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOTS - 1);
  localparam logic [8:0]        WORDS_LAST = 9'(NWORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [47:0]         fifo_mem_q [2];
  logic                rd_ptr_q;
  logic                wr_ptr_q;
  logic [1:0]          fifo_cnt_q;
  logic [1:0]          fifo_cnt_d;
  logic [4:0]          beats_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [8:0]          words_q;
  logic                wen_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WD_W-1:0]     wdata_q;
  logic [WD_W-1:0]     wdata_d;
  logic                busy_q;
  logic                done_q;

  logic                ready_w;
  logic                push_w;
  logic                drain_w;
  logic                pop_w;
  logic [47:0]         head_w;

  // Map a signed 3-bit code to its canonical representative in [0, Q).
  function automatic logic [11:0] cbd_to_modq(input logic [2:0] code);
    logic signed [2:0] v;
    int                r;
    v = signed'(code);
    if (v < 0) r = Q + int'(v);
    else       r = int'(v);
    return 12'(r);
  endfunction

  assign ready_w  = (state_q == S_RUN) && (fifo_cnt_q < 2'd2) && (beats_q < 5'd16);
  assign push_w   = i_coeffs_valid && ready_w;
  assign drain_w  = (state_q == S_RUN) && (fifo_cnt_q != 2'd0);
  assign pop_w    = drain_w && (slot_q == SLOT_LAST);
  assign head_w   = fifo_mem_q[rd_ptr_q];

  assign fifo_cnt_d = fifo_cnt_q + 2'(push_w) - 2'(pop_w);

  // Convert and pack the current slot of the head beat into one RAM word.
  always_comb begin
    wdata_d = '0;
    for (int i = 0; i < WR_COEFFS; i++) begin
      wdata_d[12*i +: 12] = cbd_to_modq(head_w[47 - 3*(int'(slot_q)*WR_COEFFS + i) -: 3]);
    end
  end

  // Beat storage; contents are only meaningful where the count says so.
  always_ff @(posedge i_clk) begin
    if (push_w) begin
      fifo_mem_q[wr_ptr_q] <= i_coeffs;
    end
  end

  // Control FSM, buffer pointers, counters and registered RAM-side outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      fifo_cnt_q <= '0;
      beats_q    <= '0;
      slot_q     <= '0;
      words_q    <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wen_q <= 1'b0;
          if (i_start) begin
            state_q    <= S_RUN;
            base_q     <= i_base_addr;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            fifo_cnt_q <= '0;
            beats_q    <= '0;
            slot_q     <= '0;
            words_q    <= '0;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          if (push_w) begin
            wr_ptr_q <= ~wr_ptr_q;
          end
          beats_q    <= beats_q + 5'(push_w);
          fifo_cnt_q <= fifo_cnt_d;
          if (drain_w) begin
            wen_q   <= 1'b1;
            addr_q  <= base_q + ADDR_W'(words_q);
            wdata_q <= wdata_d;
            words_q <= words_q + 9'd1;
            if (pop_w) begin
              slot_q   <= '0;
              rd_ptr_q <= ~rd_ptr_q;
            end else begin
              slot_q <= slot_q + 1'b1;
            end
          end else begin
            wen_q <= 1'b0;
          end
          // The last word went out on the previous edge; finish now.
          if (words_q == WORDS_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          wen_q   <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          wen_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_coeffs_ready = ready_w;
  assign o_mem_wen      = wen_q;
  assign o_mem_addr     = addr_q;
  assign o_mem_wdata    = wdata_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_cbd_poly_writer.sv
// Directed bench for cbd_poly_writer (WR_COEFFS=4, ADDR_W=8).
module tb_cbd_poly_writer;

  localparam int WRC    = 4;
  localparam int ADDR_W = 8;
  localparam int WD_W   = 12 * WRC;

  logic              clk = 1'b0;
  logic              i_rstn;
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic [47:0]       i_coeffs;
  logic              i_coeffs_valid;
  logic              o_coeffs_ready;
  logic              o_mem_wen;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [WD_W-1:0]   o_mem_wdata;
  logic              o_busy;
  logic              o_done;

  always #5 clk = ~clk;

  cbd_poly_writer #(
    .Q(3329),
    .WR_COEFFS(WRC),
    .ADDR_W(ADDR_W)
  ) dut (
    .i_clk(clk),
    .i_rstn(i_rstn),
    .i_start(i_start),
    .i_base_addr(i_base_addr),
    .i_coeffs(i_coeffs),
    .i_coeffs_valid(i_coeffs_valid),
    .o_coeffs_ready(o_coeffs_ready),
    .o_mem_wen(o_mem_wen),
    .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write/done monitor sampled on the falling edge.
  logic [ADDR_W-1:0] wa_q[$];
  logic [WD_W-1:0]   wd_q[$];
  int                done_cnt;
  time               first_wr_t, last_wr_t, done_t;

  always @(negedge clk) begin
    if (o_mem_wen === 1'b1) begin
      if (wa_q.size() == 0) first_wr_t = $time;
      wa_q.push_back(o_mem_addr);
      wd_q.push_back(o_mem_wdata);
      last_wr_t = $time;
    end
    if (o_done === 1'b1) begin
      done_cnt++;
      done_t = $time;
    end
  end

  // Hand-derived mod-3329 values for each 3-bit code.
  function automatic logic [11:0] conv_ref(input logic [2:0] c);
    case (c)
      3'd0: return 12'd0;
      3'd1: return 12'd1;
      3'd2: return 12'd2;
      3'd3: return 12'd3;
      3'd4: return 12'd3325;
      3'd5: return 12'd3326;
      3'd6: return 12'd3327;
      default: return 12'd3328;
    endcase
  endfunction

  function automatic logic [WD_W-1:0] exp_word(input logic [47:0] b, input int s);
    logic [WD_W-1:0] w;
    logic [2:0]      c;
    w = '0;
    for (int i = 0; i < WRC; i++) begin
      c = b[47 - 3*(s*WRC + i) -: 3];
      w[12*i +: 12] = conv_ref(c);
    end
    return w;
  endfunction

  logic [47:0] beats [16];
  time         acc0_t;
  int          stalls;

  task automatic fill_random();
    for (int i = 0; i < 16; i++) beats[i] = {$urandom, $urandom};
  endtask

  // Start a polynomial, feed the 16 beats, then check what reached the RAM.
  task automatic run_poly(input logic [7:0] base, input int abort_at, input bit mid_start,
                          input string tn);
    int  idx;
    bit  acc;
    int  bad_a, bad_d;
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    stalls   = 0;
    @(posedge clk); #1;
    i_start        = 1'b1;
    i_base_addr    = base;
    i_coeffs       = beats[0];
    i_coeffs_valid = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 2000 && idx < 16; cyc++) begin
      @(negedge clk);
      acc = o_coeffs_ready;
      if (!acc && o_busy) stalls++;
      @(posedge clk);
      if (acc && idx == 0) acc0_t = $time;
      #1;
      i_start = 1'b0;
      if (acc) begin
        idx++;
        if (mid_start && idx == 4) begin
          i_start     = 1'b1;
          i_base_addr = 8'h80;
        end
        if (abort_at > 0 && idx == abort_at) break;
        if (idx < 16) i_coeffs = beats[idx];
        else          i_coeffs_valid = 1'b0;
      end
    end
    i_coeffs_valid = 1'b0;
    if (abort_at > 0) begin
      check({tn, "_beats_before_abort"}, 64'(idx), 64'(abort_at));
      i_rstn = 1'b0;
      @(posedge clk); #1;
      check({tn, "_rst_wen"},   64'(o_mem_wen), 64'd0);
      check({tn, "_rst_busy"},  64'(o_busy), 64'd0);
      check({tn, "_rst_done"},  64'(o_done), 64'd0);
      check({tn, "_rst_ready"}, 64'(o_coeffs_ready), 64'd0);
      i_rstn = 1'b1;
      repeat (40) @(negedge clk);
      check({tn, "_no_done"}, 64'(done_cnt), 64'd0);
      return;
    end
    check({tn, "_beats_accepted"}, 64'(idx), 64'd16);
    for (int c = 0; c < 400 && done_cnt == 0; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    check({tn, "_nwrites"}, 64'(wa_q.size()), 64'd64);
    bad_a = 0;
    bad_d = 0;
    for (int k = 0; k < wa_q.size() && k < 64; k++) begin
      if (wa_q[k] !== 8'(int'(base) + k)) bad_a++;
      if (wd_q[k] !== exp_word(beats[k/4], k%4)) bad_d++;
    end
    check({tn, "_addr_bad"}, 64'(bad_a), 64'd0);
    check({tn, "_data_bad"}, 64'(bad_d), 64'd0);
    check({tn, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tn, "_done_after_last"}, 64'(done_t - last_wr_t), 64'd10);
    check({tn, "_first_wr_latency"}, 64'(first_wr_t - acc0_t), 64'd15);
    check({tn, "_busy_end"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    i_rstn         = 1'b0;
    i_start        = 1'b0;
    i_base_addr    = '0;
    i_coeffs       = '0;
    i_coeffs_valid = 1'b0;
    done_cnt       = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wen",   64'(o_mem_wen), 64'd0);
    check("rst_addr",  64'(o_mem_addr), 64'd0);
    check("rst_wdata", 64'(o_mem_wdata), 64'd0);
    check("rst_busy",  64'(o_busy), 64'd0);
    check("rst_done",  64'(o_done), 64'd0);
    check("rst_ready", 64'(o_coeffs_ready), 64'd0);
    i_rstn = 1'b1;

    // All-zero polynomial at 0x10: buffer must throttle the burst.
    for (int i = 0; i < 16; i++) beats[i] = '0;
    run_poly(8'h10, 0, 1'b0, "t1");
    check("t1_ready_throttled", 64'(stalls > 0), 64'd1);
    check("t1_last_addr", 64'(wa_q.size() == 64 ? wa_q[63] : 8'h00), 64'h4F);

    // Codes 0..7 twice in the first beat.
    fill_random();
    for (int j = 0; j < 16; j++) beats[0][47 - 3*j -: 3] = 3'(j % 8);
    run_poly(8'h20, 0, 1'b0, "t2");
    check("t2_word0", 64'(wd_q.size() > 0 ? wd_q[0] : '0),
          64'({12'd3, 12'd2, 12'd1, 12'd0}));
    check("t2_word1", 64'(wd_q.size() > 1 ? wd_q[1] : '0),
          64'({12'd3328, 12'd3327, 12'd3326, 12'd3325}));
    check("t2_word2", 64'(wd_q.size() > 2 ? wd_q[2] : '0),
          64'({12'd3, 12'd2, 12'd1, 12'd0}));

    // Address wrap from 0xFE.
    fill_random();
    run_poly(8'hFE, 0, 1'b0, "t3");
    check("t3_addr1", 64'(wa_q.size() > 1 ? wa_q[1] : 8'h00), 64'hFF);
    check("t3_addr2", 64'(wa_q.size() > 2 ? wa_q[2] : 8'hFF), 64'h00);
    check("t3_addr63", 64'(wa_q.size() == 64 ? wa_q[63] : 8'h00), 64'h3D);

    // Valid held in IDLE with a junk beat: nothing may be taken before RUN.
    @(posedge clk); #1;
    i_coeffs       = 48'hFFFF_FFFF_FFFF;
    i_coeffs_valid = 1'b1;
    wa_q.delete();
    wd_q.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t4_idle_ready", 64'(o_coeffs_ready), 64'd0);
    end
    check("t4_idle_writes", 64'(wa_q.size()), 64'd0);
    fill_random();
    beats[0] = 48'h0000_0000_0001;
    run_poly(8'h00, 0, 1'b0, "t4");
    check("t4_first_word", 64'(wd_q.size() > 0 ? wd_q[0] : '1), 64'd0);

    // Reset after 5 beats, then a clean polynomial from a new base.
    fill_random();
    run_poly(8'h30, 5, 1'b0, "t5a");
    fill_random();
    run_poly(8'h40, 0, 1'b0, "t5b");

    // A start pulse during RUN must not disturb the addressing.
    fill_random();
    run_poly(8'h50, 0, 1'b1, "t6");
    check("t6_last_addr", 64'(wa_q.size() == 64 ? wa_q[63] : 8'h00), 64'h8F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cbd_poly_writer.md
Name: cbd_poly_writer

Overview:
- Sits directly downstream of the CBD sampler.
- Accepts 48-bit beats of 16 signed 3-bit noise coefficients and converts each coefficient to its canonical mod-q 12-bit representative.
- Packs the converted coefficients into memory words and writes one full 256-coefficient polynomial into the polynomial RAM, starting at a base address.
- Decouples the sampler burst rate from the RAM write rate with a 2-beat buffer and a ready handshake.

Parameters:
- Q, 3329, modulus used for the negative-value mapping.
- WR_COEFFS, 4, coefficients per RAM word; legal values 1, 2, 4, 8, 16.
- ADDR_W, 8, RAM address width.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rstn  input  1  synchronous active-low reset.
- i_start  input  1  one-cycle pulse that begins a polynomial; honoured only in IDLE.
- i_base_addr  input  ADDR_W  first word address, latched on an accepted i_start.
- i_coeffs  input  48  16 x 3-bit two's-complement coefficients; [47:45] is coefficient 0 of the beat, [2:0] is coefficient 15.
- i_coeffs_valid  input  1  beat valid.
- o_coeffs_ready  output  1  beat accepted on a cycle where valid and ready are both high.
- o_mem_wen  output  1  RAM write enable.
- o_mem_addr  output  ADDR_W  RAM word address.
- o_mem_wdata  output  12*WR_COEFFS  packed coefficients; lowest-index coefficient in [11:0].
- o_busy  output  1  high in RUN.
- o_done  output  1  one-cycle pulse at end of polynomial.

Behaviour:
- Reset (sync, i_rstn=0 at a clock edge) clears all state:
  - FSM returns to IDLE.
  - FIFO is emptied; beat, slot and word counters go to 0.
  - All outputs go to 0.
  - Reset mid-polynomial abandons the operation with no done pulse.
- FSM states and transitions:
  - IDLE to RUN on i_start; the base address is latched and counters are cleared.
  - RUN to DONE in the cycle after the final (256/WR_COEFFS)-th write is issued.
  - DONE to IDLE unconditionally.
- Outputs by state:
  - o_done=1 only in DONE.
  - o_busy=1 only in RUN.
  - i_start in RUN or DONE is ignored.
- Handshake:
  - o_coeffs_ready = (state==RUN) && (fifo_count<2) && (beats_accepted<16); it is a function of registered state only.
  - Valid beats arriving while ready=0 are not captured; upstream must hold them.
  - Valid beats arriving in IDLE are never captured.
- Buffer:
  - 2-entry FIFO of 48-bit raw beats.
  - A push and a pop in the same cycle are allowed; the count stays unchanged.
- Drain:
  - While the FIFO is non-empty in RUN, one word is written per cycle.
  - The slot counter s runs 0..16/WR_COEFFS-1 over the head beat; word s takes coefficients s*WR_COEFFS .. s*WR_COEFFS+WR_COEFFS-1 of that beat.
  - The head beat is popped on its last slot.
  - When the FIFO is empty, o_mem_wen=0 and the address is held.
- Latency:
  - A beat accepted at edge t into an empty FIFO produces its first write with o_mem_wen high in the cycle after edge t+1.
  - o_mem_wen, o_mem_addr and o_mem_wdata are registered.
  - Steady throughput is one beat per 16/WR_COEFFS cycles.
- Conversion (per 3-bit code c, sign-extended to v):
  - v>=0 maps to v.
  - v<0 maps to Q+v.
  - All 8 codes are defined; code 3'b100 (v=-4) maps to 3325.
  - Output is 12-bit unsigned.
- Addressing:
  - The k-th write of the polynomial (k=0..256/WR_COEFFS-1) goes to address base+k modulo 2^ADDR_W; the address wraps silently.
- Completion:
  - Exactly 16 beats and 256/WR_COEFFS writes occur per polynomial.
  - o_done pulses one cycle after the cycle in which the final write is presented on the port.

Test Plan:
- Reset, then i_start with base=0x10, then 16 back-to-back beats of all-zero coefficients (WR_COEFFS=4) -> ready toggles, limiting the FIFO to 2 beats; 64 writes to addresses 0x10..0x4F with wdata=0; o_done high for exactly 1 cycle after the 0x4F write; busy falls.
- Single beat with coefficient codes 0..7 repeated twice ({3'd0,3'd1,...,3'd7,3'd0,...,3'd7}) -> first word {3,2,1,0} in 12-bit fields, with 0 in [11:0]; next word {3329-1=3328, 3327, 3326, 3325} ordered as codes 7,6,5,4 from the top down.
- base=0xFE, full polynomial -> addresses 0xFE, 0xFF, 0x00 ... 0x3D; wrap-around with no error.
- Valid held high in IDLE, then i_start -> no capture before RUN; first accepted beat is the one presented once ready asserts.
- Reset asserted after 5 beats -> next edge: wen=0, busy=0, no done pulse; a subsequent start writes all 64 words from the new base.
- i_start pulsed mid-RUN with base 0x80 -> ignored; addresses continue from the original base.
